// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
// The optional statistics counters are enabled with ICACHE_STATS_EN (see icache.sv).
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESPOND = 2'd1,
      REFILL  = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam int DEF_LINES       = 16;
   localparam int DEF_BLOCK_WORDS = 4;

endpackage

// File: rtl/icache_if.sv
// Fetcher-side word-fetch handshake plus the arbiter-side refill request bus.
// The cache uses the slave modport; the fetcher/arbiter side uses master.
interface icache_if;

   logic        start_fetch;
   logic [31:0] fetch_addr;
   logic        instr_ready;
   logic [31:0] instr;
   logic        clear;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;

   modport slave (
      input  start_fetch, fetch_addr, clear, mem_done, mem_data,
      output instr_ready, instr, mem_req, mem_addr
   );

   modport master (
      output start_fetch, fetch_addr, clear, mem_done, mem_data,
      input  instr_ready, instr, mem_req, mem_addr
   );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the icache: combinational read by index,
// one whole-line write port, valid bits cleared asynchronously on rst_n.
module icache_line_array #(
   parameter int LINES       = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int IDX_W       = 4,
   parameter int TAG_W       = 24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [IDX_W-1:0]                 rd_idx,
   output logic                             rd_valid,
   output logic [TAG_W-1:0]                 rd_tag,
   output logic [BLOCK_WORDS-1:0][31:0]     rd_line,
   input  logic                             we,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [TAG_W-1:0]                 wr_tag,
   input  logic [BLOCK_WORDS-1:0][31:0]     wr_line
);

   logic [LINES-1:0]                 valid;
   logic [TAG_W-1:0]                 tag_mem  [LINES];
   logic [BLOCK_WORDS-1:0][31:0]     data_mem [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the Fetcher and the memory arbiter.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache
   import icache_pkg::*;
#(
   parameter int LINES       = DEF_LINES,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OB    = $clog2(BLOCK_WORDS);
   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = 30 - OB - IB;

   state_t state, state_n;

   logic [OB-1:0]                f_off, req_off, cnt;
   logic [IB-1:0]                f_idx, req_idx;
   logic [TAG_W-1:0]             f_tag, req_tag, rd_tag;
   logic                         rd_valid, hit, accept, last, install;
   logic [BLOCK_WORDS-1:0][31:0] rd_line, fill_buf, fill_line;
   logic                         unused_addr_bits;

   assign f_off  = bus.fetch_addr[OB+1:2];
   assign f_idx  = bus.fetch_addr[OB+IB+1:OB+2];
   assign f_tag  = bus.fetch_addr[31:OB+IB+2];
   assign unused_addr_bits = ^bus.fetch_addr[1:0];

   assign hit    = rd_valid && (rd_tag == f_tag);
   assign accept = (state == IDLE) && bus.start_fetch && !bus.clear;
   assign last   = (cnt == OB'(BLOCK_WORDS - 1));

   icache_line_array #(
      .LINES(LINES), .BLOCK_WORDS(BLOCK_WORDS), .IDX_W(IB), .TAG_W(TAG_W)
   ) u_lines (
      .clk(clk), .rst_n(rst_n),
      .rd_idx(f_idx), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_line(rd_line),
      .we(install), .wr_idx(req_idx), .wr_tag(req_tag), .wr_line(fill_line)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else if (rdy) state <= state_n;
   end

   // clear dominates; an in-flight arbiter word must still be retired via DRAIN.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = hit ? RESPOND : REFILL;
         RESPOND: state_n = IDLE;
         REFILL: begin
            if (bus.clear) state_n = bus.mem_done ? IDLE : DRAIN;
            else if (bus.mem_done && last) state_n = RESPOND;
         end
         DRAIN:   if (bus.mem_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.instr_ready = (state == RESPOND) && !bus.clear;
      install         = rdy && (state == REFILL) && bus.mem_done && last && !bus.clear;
      fill_line       = fill_buf;
      fill_line[cnt]  = bus.mem_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.instr    <= '0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (accept && hit) begin
                  bus.instr <= rd_line[f_off];
               end else if (accept) begin
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= {f_tag, f_idx, {(OB + 2){1'b0}}};
               end
            end
            REFILL: begin
               if (bus.mem_done) begin
                  if (bus.clear || last) bus.mem_req <= 1'b0;
                  else bus.mem_addr <= bus.mem_addr + 32'd4;
                  if (!bus.clear && last) bus.instr <= fill_line[req_off];
               end
            end
            DRAIN:   if (bus.mem_done) bus.mem_req <= 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rdy) begin
         if (accept && !hit) begin
            req_off <= f_off;
            req_idx <= f_idx;
            req_tag <= f_tag;
            cnt     <= '0;
         end
         if (state == REFILL && bus.mem_done) begin
            fill_buf[cnt] <= bus.mem_data;
            cnt           <= cnt + OB'(1);
         end
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (rdy && accept) begin
         if (hit) hit_count  <= hit_count + 32'd1;
         else     miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule
